// File: rtl/multi_latency_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// multi_latency_hazard_scoreboard
//
// ID-stage hazard detector for a WAYS-wide in-order issue bundle. It keeps a
// per-register countdown of in-flight long-latency results (loads and
// multiplies). Each cycle it decides how many of the oldest ways may advance
// into ID/EX. The remaining valid ways are reported as rollback.
//
// Ports:
//   clock        in   pipeline clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   en           in   ID/EX advance enable (0 = pipeline frozen)
//   squash       in   flush of all in-flight producers
//   way_valid    in   [WAYS]          per-way valid, contiguous from way 0
//   rs1_idx      in   [WAYS][IDX_W]   source 1 register per way
//   rs2_idx      in   [WAYS][IDX_W]   source 2 register per way
//   uses_rs1     in   [WAYS]          source 1 is actually read
//   uses_rs2     in   [WAYS]          source 2 is actually read
//   dest_idx     in   [WAYS][IDX_W]   destination per way (0 = none)
//   is_load      in   [WAYS]          way is a load
//   is_mul       in   [WAYS]          way is a multiply (load wins if both)
//   issue_cnt    out  [RB_W]          ways 0..issue_cnt-1 advance this cycle
//   rollback     out  [RB_W]          valid ways that do not advance
//   stall_cycles out  [32]            saturating count of stalled enabled cycles
// -----------------------------------------------------------------------------
module multi_latency_hazard_scoreboard #(
    parameter int WAYS     = 4,
    parameter int NUM_REGS = 32,
    parameter int LOAD_LAT = 2,
    parameter int MUL_LAT  = 4
) (
    input  logic                                     clock,
    input  logic                                     reset_n,
    input  logic                                     en,
    input  logic                                     squash,
    input  logic [WAYS-1:0]                          way_valid,
    input  logic [WAYS-1:0][$clog2(NUM_REGS)-1:0]    rs1_idx,
    input  logic [WAYS-1:0][$clog2(NUM_REGS)-1:0]    rs2_idx,
    input  logic [WAYS-1:0]                          uses_rs1,
    input  logic [WAYS-1:0]                          uses_rs2,
    input  logic [WAYS-1:0][$clog2(NUM_REGS)-1:0]    dest_idx,
    input  logic [WAYS-1:0]                          is_load,
    input  logic [WAYS-1:0]                          is_mul,
    output logic [$clog2(WAYS+1)-1:0]                issue_cnt,
    output logic [$clog2(WAYS+1)-1:0]                rollback,
    output logic [31:0]                              stall_cycles
);

    localparam int IDX_W   = $clog2(NUM_REGS);
    localparam int RB_W    = $clog2(WAYS + 1);
    localparam int MAX_LAT = (LOAD_LAT > MUL_LAT) ? LOAD_LAT : MUL_LAT;
    // The largest stored value is MAX_LAT-1, so clog2(MAX_LAT) bits suffice.
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    // Stored value is LAT-1: a count of 0 means a consumer may issue next cycle.
    localparam logic [CNT_W-1:0] LOAD_M1 = CNT_W'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] MUL_M1  = CNT_W'(MUL_LAT - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [NUM_REGS-1:0][CNT_W-1:0] busy_q, busy_d;
    logic [31:0]                    stall_q, stall_d;

    // ------------------------------------------------------------------------
    // Bundle decode
    // ------------------------------------------------------------------------
    logic [WAYS-1:0]            in_bundle;   // contiguous valid prefix
    logic [WAYS-1:0]            blocked;     // way has a blocked source
    logic [WAYS-1:0]            issue_mask;  // way advances this cycle
    logic [WAYS-1:0][CNT_W-1:0] lat_m1;      // LAT-1 of each way
    logic [RB_W-1:0]            valid_cnt;
    logic [RB_W-1:0]            issue_cnt_w;
    logic                       advance;     // pipeline may move this cycle

    assign advance = en & ~squash;

    // The first invalid way ends the bundle, so a stray valid bit past a gap
    // can never issue or be counted.
    // NOTE: every variable written in a combinational block gets a default
    // first; otherwise a path that skips the assignment infers a latch.
    always_comb begin
        logic run;
        in_bundle = '0;
        valid_cnt = '0;
        run       = 1'b1;
        for (int k = 0; k < WAYS; k++) begin
            run          = run & way_valid[k];
            in_bundle[k] = run;
            if (run) begin
                valid_cnt = valid_cnt + RB_W'(1);
            end
        end
    end

    // A source is blocked when it is read, is not r0, and either its register
    // is still counting down or an older way in this bundle writes it. There
    // is no intra-bundle forwarding, so any older writer blocks the read.
    always_comb begin
        logic b1;
        logic b2;
        blocked = '0;
        for (int k = 0; k < WAYS; k++) begin
            b1 = uses_rs1[k] && (rs1_idx[k] != '0) && (busy_q[rs1_idx[k]] != '0);
            b2 = uses_rs2[k] && (rs2_idx[k] != '0) && (busy_q[rs2_idx[k]] != '0);
            for (int i = 0; i < k; i++) begin
                if (dest_idx[i] != '0) begin
                    if (uses_rs1[k] && (rs1_idx[k] == dest_idx[i])) b1 = 1'b1;
                    if (uses_rs2[k] && (rs2_idx[k] == dest_idx[i])) b2 = 1'b1;
                end
            end
            blocked[k] = b1 | b2;
        end
    end

    // In-order issue: a way advances only if every older way advanced.
    always_comb begin
        logic go;
        issue_mask  = '0;
        issue_cnt_w = '0;
        go          = advance;
        for (int k = 0; k < WAYS; k++) begin
            go            = go & in_bundle[k] & ~blocked[k];
            issue_mask[k] = go;
            if (go) begin
                issue_cnt_w = issue_cnt_w + RB_W'(1);
            end
        end
    end

    // Per-way producer latency; a load takes priority over a multiply.
    always_comb begin
        lat_m1 = '0;
        for (int k = 0; k < WAYS; k++) begin
            if (is_load[k]) begin
                lat_m1[k] = LOAD_M1;
            end else if (is_mul[k]) begin
                lat_m1[k] = MUL_M1;
            end else begin
                lat_m1[k] = '0;
            end
        end
    end

    assign issue_cnt = issue_cnt_w;
    assign rollback  = valid_cnt - issue_cnt_w;

    // ------------------------------------------------------------------------
    // Scoreboard next state
    // ------------------------------------------------------------------------
    // The new count is the max of the aged count and every issuing writer's
    // LAT-1. Taking the max keeps a younger short-latency write from hiding
    // an older long-latency producer to the same register (WAW ordering).
    always_comb begin
        logic [CNT_W-1:0] cand;
        busy_d = busy_q;
        for (int r = 0; r < NUM_REGS; r++) begin
            cand = busy_q[r];
            if (squash) begin
                cand = '0;
            end else if (en) begin
                cand = (busy_q[r] != '0) ? busy_q[r] - CNT_W'(1) : '0;
                for (int k = 0; k < WAYS; k++) begin
                    if (issue_mask[k] && (dest_idx[k] == IDX_W'(r)) && (lat_m1[k] > cand)) begin
                        cand = lat_m1[k];
                    end
                end
            end
            busy_d[r] = cand;
        end
        // r0 is hard-wired and never tracked as busy.
        busy_d[0] = '0;
    end

    // Stalls are only counted while the pipeline is actually trying to move.
    always_comb begin
        stall_d = stall_q;
        if (advance && (rollback != '0) && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    // NOTE: the scoreboard array is control state, not a data memory, so it
    // is reset; a stale count after reset would block the first bundle.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_q  <= '0;
            stall_q <= '0;
        end else begin
            busy_q  <= busy_d;
            stall_q <= stall_d;
        end
    end

endmodule

// File: tb/tb_multi_latency_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// Testbench for multi_latency_hazard_scoreboard.
// A driver applies one bundle per cycle and pushes the expected outputs into a
// queue. A monitor pops and compares on each falling edge. The reference model
// tracks, per register, the enabled-cycle time at which its value becomes
// readable, instead of tracking countdown counters.
// -----------------------------------------------------------------------------
module tb_multi_latency_hazard_scoreboard;

    localparam int WAYS     = 4;
    localparam int NUM_REGS = 32;
    localparam int LOAD_LAT = 2;
    localparam int MUL_LAT  = 4;
    localparam int IDX_W    = 5;
    localparam int RB_W     = 3;

    typedef struct packed {
        logic                        en;
        logic                        sq;
        logic [WAYS-1:0]             wv;
        logic [WAYS-1:0]             u1;
        logic [WAYS-1:0]             u2;
        logic [WAYS-1:0]             ld;
        logic [WAYS-1:0]             ml;
        logic [WAYS-1:0][IDX_W-1:0]  rs1;
        logic [WAYS-1:0][IDX_W-1:0]  rs2;
        logic [WAYS-1:0][IDX_W-1:0]  dst;
    } bundle_t;

    typedef struct {
        int id;
        int iss;
        int rb;
        int st;
    } exp_t;

    logic                        clock;
    logic                        reset_n;
    logic                        en;
    logic                        squash;
    logic [WAYS-1:0]             way_valid;
    logic [WAYS-1:0][IDX_W-1:0]  rs1_idx;
    logic [WAYS-1:0][IDX_W-1:0]  rs2_idx;
    logic [WAYS-1:0]             uses_rs1;
    logic [WAYS-1:0]             uses_rs2;
    logic [WAYS-1:0][IDX_W-1:0]  dest_idx;
    logic [WAYS-1:0]             is_load;
    logic [WAYS-1:0]             is_mul;
    logic [RB_W-1:0]             issue_cnt;
    logic [RB_W-1:0]             rollback;
    logic [31:0]                 stall_cycles;

    multi_latency_hazard_scoreboard #(
        .WAYS(WAYS), .NUM_REGS(NUM_REGS), .LOAD_LAT(LOAD_LAT), .MUL_LAT(MUL_LAT)
    ) dut (
        .clock(clock), .reset_n(reset_n), .en(en), .squash(squash),
        .way_valid(way_valid), .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
        .uses_rs1(uses_rs1), .uses_rs2(uses_rs2), .dest_idx(dest_idx),
        .is_load(is_load), .is_mul(is_mul),
        .issue_cnt(issue_cnt), .rollback(rollback), .stall_cycles(stall_cycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];
    int   seq      = 0;

    // Reference model state.
    int ready_at[NUM_REGS];   // enabled-cycle time when the register is readable
    int now_t   = 0;          // number of enabled, unsquashed edges so far
    int stall_m = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic void model_clear_regs();
        for (int r = 0; r < NUM_REGS; r++) ready_at[r] = 0;
    endfunction

    function automatic bit src_blocked(input bundle_t b, input int k, input int idx, input bit used);
        if (!used || idx == 0) return 1'b0;
        if (ready_at[idx] > now_t) return 1'b1;
        for (int i = 0; i < k; i++) begin
            if (int'(b.dst[i]) == idx) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic void model_eval(input bundle_t b, output int iss, output int vc);
        vc  = 0;
        iss = 0;
        for (int k = 0; k < WAYS; k++) if (b.wv[k]) vc++;
        if (b.en && !b.sq) begin
            for (int k = 0; k < vc; k++) begin
                if (src_blocked(b, k, int'(b.rs1[k]), b.u1[k]) ||
                    src_blocked(b, k, int'(b.rs2[k]), b.u2[k])) break;
                iss++;
            end
        end
    endfunction

    function automatic void model_commit(input bundle_t b, input int iss, input int vc);
        int lat;
        int d;
        if (b.sq) begin
            model_clear_regs();
        end else if (b.en) begin
            for (int k = 0; k < iss; k++) begin
                d   = int'(b.dst[k]);
                lat = b.ld[k] ? LOAD_LAT : (b.ml[k] ? MUL_LAT : 1);
                if (d != 0 && now_t + lat > ready_at[d]) ready_at[d] = now_t + lat;
            end
            if (vc - iss != 0) stall_m++;
            now_t++;
        end
    endfunction

    // Apply one bundle for one cycle. exp_iss >= 0 supplies a hand-derived
    // issue count for the directed cases; -1 takes the model's value.
    task automatic drive(input bundle_t b, input int exp_iss);
        int   iss;
        int   vc;
        exp_t e;
        assert (((b.wv + 4'd1) & b.wv) == 4'd0)
            else $error("way_valid not contiguous: %b", b.wv);
        en        = b.en;
        squash    = b.sq;
        way_valid = b.wv;
        rs1_idx   = b.rs1;
        rs2_idx   = b.rs2;
        uses_rs1  = b.u1;
        uses_rs2  = b.u2;
        dest_idx  = b.dst;
        is_load   = b.ld;
        is_mul    = b.ml;
        model_eval(b, iss, vc);
        e.id  = seq++;
        e.iss = (exp_iss >= 0) ? exp_iss : iss;
        e.rb  = vc - e.iss;
        e.st  = stall_m;
        exp_q.push_back(e);
        @(posedge clock);
        model_commit(b, iss, vc);
        #1;
    endtask

    // Async reset pulse placed between edges; the model clears with it.
    task automatic pulse_reset();
        reset_n = 1'b0;
        model_clear_regs();
        stall_m = 0;
        #2;
        reset_n = 1'b1;
    endtask

    function automatic void add_way(inout bundle_t b, input int k, input int d,
                                    input int s1, input int s2, input bit ld, input bit ml);
        b.wv[k]  = 1'b1;
        b.u1[k]  = 1'b1;
        b.u2[k]  = 1'b1;
        b.dst[k] = IDX_W'(d);
        b.rs1[k] = IDX_W'(s1);
        b.rs2[k] = IDX_W'(s2);
        b.ld[k]  = ld;
        b.ml[k]  = ml;
    endfunction

    function automatic bundle_t empty_bundle(input bit e);
        bundle_t b;
        b    = '0;
        b.en = e;
        return b;
    endfunction

    // Monitor: outputs are combinational, so every cycle presents a response.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check($sformatf("issue_cnt[%0d]", e.id), int'(issue_cnt), e.iss);
            check($sformatf("rollback[%0d]", e.id), int'(rollback), e.rb);
            check($sformatf("stall_cycles[%0d]", e.id), int'(stall_cycles), e.st);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bundle_t b;
        int      en_pat[6];
        int      ex_pat[6];
        model_clear_regs();
        reset_n   = 1'b0;
        en        = 1'b0;
        squash    = 1'b0;
        way_valid = '0;
        rs1_idx   = '0;
        rs2_idx   = '0;
        uses_rs1  = '0;
        uses_rs2  = '0;
        dest_idx  = '0;
        is_load   = '0;
        is_mul    = '0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Four independent ALU ops.
        b = empty_bundle(1'b1);
        for (int k = 0; k < 4; k++) add_way(b, k, 1 + k, 5 + k, 5 + k, 1'b0, 1'b0);
        drive(b, 4);

        // Load to r3 in way 0; way 2 reads r3 in the same bundle.
        b = empty_bundle(1'b1);
        add_way(b, 0, 3, 10, 11, 1'b1, 1'b0);
        add_way(b, 1, 12, 13, 13, 1'b0, 1'b0);
        add_way(b, 2, 14, 3, 3, 1'b0, 1'b0);
        add_way(b, 3, 15, 16, 16, 1'b0, 1'b0);
        drive(b, 2);
        // Rebundled with the r3 reader in way 0: blocked once, then all issue.
        b = empty_bundle(1'b1);
        add_way(b, 0, 14, 3, 3, 1'b0, 1'b0);
        add_way(b, 1, 15, 16, 16, 1'b0, 1'b0);
        add_way(b, 2, 17, 19, 19, 1'b0, 1'b0);
        add_way(b, 3, 18, 20, 20, 1'b0, 1'b0);
        drive(b, 0);
        drive(b, 4);

        // Multiply to r9, then a reader every cycle: blocked exactly 3 cycles.
        b = empty_bundle(1'b1);
        add_way(b, 0, 9, 1, 2, 1'b0, 1'b1);
        drive(b, 1);
        b = empty_bundle(1'b1);
        add_way(b, 0, 21, 9, 9, 1'b0, 1'b0);
        drive(b, 0);
        drive(b, 0);
        drive(b, 0);
        drive(b, 1);

        // Same again with en low for two cycles: the block stretches to 5.
        b = empty_bundle(1'b1);
        add_way(b, 0, 9, 1, 2, 1'b0, 1'b1);
        drive(b, 1);
        en_pat = '{1, 0, 0, 1, 1, 1};
        ex_pat = '{0, 0, 0, 0, 0, 1};
        for (int c = 0; c < 6; c++) begin
            b = empty_bundle(en_pat[c] != 0);
            add_way(b, 0, 21, 9, 9, 1'b0, 1'b0);
            drive(b, ex_pat[c]);
        end

        // WAW: a younger ALU write to r9 must not hide the older multiply.
        b = empty_bundle(1'b1);
        add_way(b, 0, 9, 1, 2, 1'b0, 1'b1);
        drive(b, 1);
        b = empty_bundle(1'b1);
        add_way(b, 0, 9, 1, 2, 1'b0, 1'b0);
        drive(b, 1);
        b = empty_bundle(1'b1);
        add_way(b, 0, 21, 9, 9, 1'b0, 1'b0);
        drive(b, 0);
        drive(b, 0);
        drive(b, 1);

        // Squash while r9 is busy clears the scoreboard.
        b = empty_bundle(1'b1);
        add_way(b, 0, 9, 1, 2, 1'b0, 1'b1);
        drive(b, 1);
        b = empty_bundle(1'b1);
        b.sq = 1'b1;
        for (int k = 0; k < 4; k++) add_way(b, k, 1 + k, 5 + k, 5 + k, 1'b0, 1'b0);
        drive(b, 0);
        b = empty_bundle(1'b1);
        add_way(b, 0, 21, 9, 9, 1'b0, 1'b0);
        for (int k = 1; k < 4; k++) add_way(b, k, 1 + k, 5 + k, 5 + k, 1'b0, 1'b0);
        drive(b, 4);

        // r0 everywhere (including a load to r0), then an unused rs2 match.
        b = empty_bundle(1'b1);
        for (int k = 0; k < 4; k++) add_way(b, k, 0, 0, 0, k == 0, k == 1);
        drive(b, 4);
        b = empty_bundle(1'b1);
        add_way(b, 0, 23, 0, 0, 1'b0, 1'b0);
        add_way(b, 1, 0, 0, 23, 1'b0, 1'b0);
        b.u2[1] = 1'b0;
        add_way(b, 2, 0, 0, 0, 1'b0, 1'b0);
        add_way(b, 3, 0, 0, 0, 1'b0, 1'b0);
        drive(b, 4);

        // Reset pulse in the middle of a stall.
        b = empty_bundle(1'b1);
        add_way(b, 0, 9, 1, 2, 1'b0, 1'b1);
        drive(b, 1);
        b = empty_bundle(1'b1);
        add_way(b, 0, 21, 9, 9, 1'b0, 1'b0);
        drive(b, 0);
        pulse_reset();
        drive(b, 1);

        // Randomized traffic over a small register window to force hazards.
        for (int n = 0; n < 500; n++) begin
            int nv;
            b    = empty_bundle($urandom_range(0, 9) != 0);
            b.sq = ($urandom_range(0, 19) == 0);
            nv   = $urandom_range(0, 4);
            for (int k = 0; k < nv; k++) begin
                add_way(b, k, $urandom_range(0, 7), $urandom_range(0, 7),
                        $urandom_range(0, 7), $urandom_range(0, 3) == 0,
                        $urandom_range(0, 3) == 0);
                b.u1[k] = 1'($urandom_range(0, 1));
                b.u2[k] = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 59) == 0) pulse_reset();
            drive(b, -1);
        end

        repeat (3) @(negedge clock);
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
